// File: rtl/rotate_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : rotate_key_conditioner
// Purpose  : Two active-low rotation keys -> synchronised, debounced one-cycle
//            step pulses, with optional auto-repeat (macro ROTATE_AUTOREPEAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module rotate_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] key_n,
    output logic       rotate_left,
    output logic       rotate_right,
    output logic [1:0] held
);

    localparam int c_MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int c_MAX    = (c_MAX_AB > REPEAT_PERIOD) ? c_MAX_AB : REPEAT_PERIOD;
    localparam int c_CNT_W  = $clog2(c_MAX);

    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

`ifdef ROTATE_AUTOREPEAT_EN
    localparam logic [c_CNT_W-1:0] c_RD_LAST = c_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_RP_LAST = c_CNT_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DELAY  = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;
`endif

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_held;
    logic [1:0] w_s;
    logic [1:0] w_held_nxt;
    logic [1:0] w_step;
    logic       w_conflict;
    logic       r_rot_left;
    logic       r_rot_right;

    // Synchronisers reset to the released level so a key held through reset
    // has to be re-seen and re-debounced.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = ~r_sync2;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_ch
        logic [c_CNT_W-1:0] r_db_cnt;
        logic               w_db_done;

        assign w_db_done      = (w_s[gi] != r_held[gi]) && (r_db_cnt == c_DB_LAST);
        assign w_held_nxt[gi] = w_db_done ? w_s[gi] : r_held[gi];

        always_ff @(posedge clock) begin
            if (reset || (w_s[gi] == r_held[gi]) || w_db_done) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_CNT_ONE;
            end
        end

`ifdef ROTATE_AUTOREPEAT_EN
        logic [1:0]         r_state;
        logic [c_CNT_W-1:0] r_rc;
        logic               w_rc_hit;

        always_comb begin
            w_rc_hit = 1'b0;
            case (r_state)
                c_ST_DELAY:  w_rc_hit = (r_rc == c_RD_LAST);
                c_ST_REPEAT: w_rc_hit = (r_rc == c_RP_LAST);
                default:     w_rc_hit = 1'b0;
            endcase
        end

        // FSM runs on the next held value so the press pulse lines up with
        // the first cycle held reads 1; a release suppresses any due pulse.
        assign w_step[gi] = w_held_nxt[gi] &&
                            (((r_state == c_ST_IDLE) && !r_held[gi]) || w_rc_hit);

        always_ff @(posedge clock) begin
            if (reset || !w_held_nxt[gi]) begin
                r_state <= c_ST_IDLE;
                r_rc    <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_rc <= '0;
                        if (!r_held[gi]) begin
                            r_state <= c_ST_DELAY;
                        end
                    end
                    c_ST_DELAY: begin
                        if (w_rc_hit) begin
                            r_state <= c_ST_REPEAT;
                            r_rc    <= '0;
                        end else begin
                            r_rc <= r_rc + c_CNT_ONE;
                        end
                    end
                    c_ST_REPEAT: begin
                        if (w_rc_hit) begin
                            r_rc <= '0;
                        end else begin
                            r_rc <= r_rc + c_CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_rc    <= '0;
                    end
                endcase
            end
        end
`else
        assign w_step[gi] = w_held_nxt[gi] && !r_held[gi];
`endif
    end

    // Both keys down: steps are masked but the per-channel schedules keep going.
    assign w_conflict = (w_held_nxt == 2'b11);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_held      <= 2'b00;
            r_rot_left  <= 1'b0;
            r_rot_right <= 1'b0;
        end else begin
            r_held      <= w_held_nxt;
            r_rot_left  <= w_step[1] && !w_conflict;
            r_rot_right <= w_step[0] && !w_conflict;
        end
    end

    assign held         = r_held;
    assign rotate_left  = r_rot_left;
    assign rotate_right = r_rot_right;

endmodule
`default_nettype wire

// File: tb/tb_rotate_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotate_key_conditioner
// Purpose  : Directed table-driven bench for rotate_key_conditioner
//            (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotate_key_conditioner;

`ifdef ROTATE_AUTOREPEAT_EN
    localparam bit c_AR = 1'b1;
`else
    localparam bit c_AR = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] key_n = 2'b11;
    logic       rotate_left;
    logic       rotate_right;
    logic [1:0] held;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int q_left[$];
    int q_right[$];
    int exp_l[$];

    typedef struct {
        logic       rst;
        logic [1:0] key_n;
        int         n;
        int         exp_l;
        int         exp_r;
        logic [1:0] exp_held;
    } seg_t;

    seg_t segs[$];

    rotate_key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_n       (key_n),
        .rotate_left (rotate_left),
        .rotate_right(rotate_right),
        .held        (held)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rotate_left)  q_left.push_back(cyc);
        if (rotate_right) q_right.push_back(cyc);
        if (rotate_left && rotate_right) begin
            errors++;
            $display("FAIL both_pulses at cyc %0d: got left=1 right=1, required at most one", cyc);
        end
    end

    function automatic seg_t mk(input logic rst, input logic [1:0] k, input int n,
                                input int el, input int er, input logic [1:0] eh);
        seg_t s;
        s.rst = rst; s.key_n = k; s.n = n; s.exp_l = el; s.exp_r = er; s.exp_held = eh;
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, expv);
        end
    endtask

    task automatic check_pulses(input string name, input int base);
        chk({name, "_left_count"}, q_left.size(), exp_l.size());
        for (int i = 0; i < q_left.size() && i < exp_l.size(); i++)
            chk($sformatf("%s_left_offset%0d", name, i), q_left[i] - base, exp_l[i]);
        chk({name, "_right_count"}, q_right.size(), 0);
    endtask

    initial begin
        seg_t       s;
        int         nl;
        int         nr;
        int         base;
        logic [1:0] last_held;

        // Reset with both keys down, then both debounce together (masked).
        segs.push_back(mk(1'b1, 2'b00, 5, 0, 0, 2'b00));
        segs.push_back(mk(1'b0, 2'b00, 10, 0, 0, 2'b11));
        segs.push_back(mk(1'b0, 2'b11, 10, 0, 0, 2'b00));
        // Left key bouncing with 2-cycle runs, then a clean press.
        for (int k = 0; k < 5; k++) begin
            segs.push_back(mk(1'b0, 2'b01, 2, 0, 0, 2'b00));
            segs.push_back(mk(1'b0, 2'b11, 2, 0, 0, 2'b00));
        end
        segs.push_back(mk(1'b0, 2'b01, 10, 1, 0, 2'b10));
        // Release lands on the first repeat slot: release wins, no pulse.
        segs.push_back(mk(1'b0, 2'b11, 10, 0, 0, 2'b00));
        // Long left hold: 6,16,19,...,37 then 40,43 before held drops.
        segs.push_back(mk(1'b0, 2'b01, 40, c_AR ? 9 : 1, 0, 2'b10));
        segs.push_back(mk(1'b0, 2'b11, 10, c_AR ? 2 : 0, 0, 2'b00));
        // Short right press released inside DELAY.
        segs.push_back(mk(1'b0, 2'b10, 8, 0, 1, 2'b01));
        segs.push_back(mk(1'b0, 2'b11, 10, 0, 0, 2'b00));

        @(posedge clock);
        #1;
        for (int i = 0; i < segs.size(); i++) begin
            s     = segs[i];
            reset = s.rst;
            key_n = s.key_n;
            nl    = 0;
            nr    = 0;
            last_held = 2'bxx;
            for (int j = 0; j < s.n; j++) begin
                @(negedge clock);
                nl += int'(rotate_left);
                nr += int'(rotate_right);
                last_held = held;
                @(posedge clock);
                #1;
            end
            chk($sformatf("seg%0d_left_pulses", i), nl, s.exp_l);
            chk($sformatf("seg%0d_right_pulses", i), nr, s.exp_r);
            chk($sformatf("seg%0d_held", i), int'(last_held), int'(s.exp_held));
        end

        // Exact repeat grid while left is held.
        q_left.delete(); q_right.delete();
        base  = cyc;
        key_n = 2'b01;
        tick(30);
        if (c_AR) exp_l = {6, 16, 19, 22, 25, 28};
        else      exp_l = {6};
        check_pulses("hold_left", base);
        key_n = 2'b11;
        tick(12);

        // Conflict: right joins at t0+11, leaves later; left keeps its grid.
        q_left.delete(); q_right.delete();
        base  = cyc;
        key_n = 2'b01;
        tick(11);
        key_n = 2'b00;
        tick(9);
        key_n = 2'b01;
        tick(17);
        if (c_AR) exp_l = {6, 16, 28, 31, 34};
        else      exp_l = {6};
        check_pulses("conflict", base);
        key_n = 2'b11;
        tick(12);

        // Reset while left held: everything restarts with a fresh press.
        q_left.delete(); q_right.delete();
        base  = cyc;
        key_n = 2'b01;
        tick(18);
        reset = 1'b1;
        tick(1);
        chk("reset_mid_held", int'(held), 0);
        chk("reset_mid_left", int'(rotate_left), 0);
        tick(1);
        reset = 1'b0;
        tick(11);
        if (c_AR) exp_l = {6, 16, 26};
        else      exp_l = {6, 26};
        check_pulses("reset_mid", base);
        key_n = 2'b11;
        tick(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
